ram_moc_param: RTL and testbench



---
 rtl/ram_moc_param_pkg.sv | 25 ++
 rtl/ram_moc_param_if.sv | 17 +
 rtl/ram_byte_array.sv | 30 +++
 rtl/ram_moc_param.sv | 147 ++++++++++++++
 tb/tb_ram_moc_param.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_moc_param_pkg.sv
// rtl/ram_moc_param_pkg.sv - shared size encodings and FSM states for ram_moc_param
package ram_moc_param_pkg;

    localparam logic [1:0] MS_BYTE  = 2'b00;
    localparam logic [1:0] MS_HALF  = 2'b01;
    localparam logic [1:0] MS_WORD  = 2'b10;
    localparam logic [1:0] MS_DWORD = 2'b11;
    localparam int         MS_SIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            MS_BYTE: is_misaligned = 1'b0;
            MS_HALF: is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/ram_moc_param_if.sv
// rtl/ram_moc_param_if.sv - MOV/MOC memory request bus
interface ram_moc_param_if;
    logic        MOV;
    logic        RW;
    logic [2:0]  MS;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        MOC;
    logic [31:0] DataOut;
    logic        BEAT;
    logic        FAULT;

    modport master (output MOV, RW, MS, Address, DataIn,
                    input  MOC, DataOut, BEAT, FAULT);
    modport slave  (input  MOV, RW, MS, Address, DataIn,
                    output MOC, DataOut, BEAT, FAULT);
endinterface

// File: rtl/ram_byte_array.sv
// rtl/ram_byte_array.sv - DEPTH x 8 storage with 4-lane big-endian access
module ram_byte_array #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] base,
    input  logic          we,
    input  logic [3:0]    lane_en,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0] mem [DEPTH];

    // Lane k addresses byte base+k and carries bits [31-8k -: 8]; the AW-bit sum wraps.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we && lane_en[k]) begin
                mem[base + AW'(k)] <= wdata[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            rdata[31-8*k -: 8] = mem[base + AW'(k)];
        end
    end
endmodule

// File: rtl/ram_moc_param.sv
// rtl/ram_moc_param.sv - parametrised big-endian RAM with MOV/MOC handshake
module ram_moc_param
    import ram_moc_param_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int ALIGN_CHECK = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    ram_moc_param_if.slave  bus
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [AW-1:0]   addr_q;
    logic            rw_q;
    logic [2:0]      ms_q;
    logic [31:0]     data_q;
    logic            beat_q, fault_q;
    logic [31:0]     data_out_q;

    logic [AW-1:0]   req_addr;
    logic            req_fault;
    logic            do_capture, do_count, do_access, do_beat1, do_exit;
    logic [3:0]      lane_en;
    logic [31:0]     wword, rword, load_val;
    logic            unused_addr_hi;

    assign unused_addr_hi = &{1'b0, bus.Address[31:AW]};

    // Without alignment checking the address is forced down to the natural boundary.
    always_comb begin
        req_addr = bus.Address[AW-1:0];
        if (ALIGN_CHECK == 0) begin
            case (bus.MS[1:0])
                MS_HALF:          req_addr[0]   = 1'b0;
                MS_WORD, MS_DWORD: req_addr[1:0] = 2'b00;
                default:          ;
            endcase
        end
    end

    assign req_fault = (ALIGN_CHECK != 0) && is_misaligned(bus.MS[1:0], bus.Address[1:0]);

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_count   = 1'b0;
        do_access  = 1'b0;
        do_beat1   = 1'b0;
        do_exit    = 1'b0;
        case (state)
            ST_IDLE: if (bus.MOV) begin
                do_capture = 1'b1;
                state_nxt  = req_fault ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: if (cnt == 4'd0) begin
                do_access = 1'b1;
                state_nxt = ST_ACK;
            end else begin
                do_count = 1'b1;
            end
            ST_ACK: if (!bus.MOV) begin
                do_exit   = 1'b1;
                state_nxt = (ms_q[1:0] == MS_DWORD && !beat_q && !fault_q) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: if (bus.MOV) begin
                do_beat1  = 1'b1;
                state_nxt = ST_WAIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        case (ms_q[1:0])
            MS_BYTE: begin lane_en = 4'b0001; wword = {data_q[7:0], 24'b0};  end
            MS_HALF: begin lane_en = 4'b0011; wword = {data_q[15:0], 16'b0}; end
            default: begin lane_en = 4'b1111; wword = data_q;                end
        endcase
    end

    always_comb begin
        case (ms_q[1:0])
            MS_BYTE: load_val = {{24{ms_q[MS_SIGNED_BIT] & rword[31]}}, rword[31:24]};
            MS_HALF: load_val = {{16{ms_q[MS_SIGNED_BIT] & rword[31]}}, rword[31:16]};
            default: load_val = rword;
        endcase
    end

    ram_byte_array #(.DEPTH(DEPTH)) u_array (
        .clk     (CLK),
        .base    (addr_q),
        .we      (do_access && !rw_q && !RESET),
        .lane_en (lane_en),
        .wdata   (wword),
        .rdata   (rword)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt        <= 4'd0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            ms_q       <= 3'b000;
            data_q     <= 32'd0;
            beat_q     <= 1'b0;
            fault_q    <= 1'b0;
            data_out_q <= 32'd0;
        end else begin
            if (do_capture) begin
                addr_q  <= req_addr;
                rw_q    <= bus.RW;
                ms_q    <= bus.MS;
                data_q  <= bus.DataIn;
                cnt     <= WS4;
                fault_q <= req_fault;
            end
            if (do_count) cnt <= cnt - 4'd1;
            if (do_access && rw_q) data_out_q <= load_val;
            // Second doubleword beat reuses RW/MS from beat 0; only write data is re-captured.
            if (do_beat1) begin
                addr_q <= addr_q + AW'(4);
                data_q <= bus.DataIn;
                cnt    <= WS4;
                beat_q <= 1'b1;
            end
            if (do_exit) begin
                beat_q  <= 1'b0;
                fault_q <= 1'b0;
            end
        end
    end

    assign bus.MOC     = (state == ST_ACK);
    assign bus.DataOut = data_out_q;
    assign bus.BEAT    = beat_q;
    assign bus.FAULT   = fault_q;
endmodule

// File: tb/tb_ram_moc_param.sv
// tb/tb_ram_moc_param.sv - directed self-checking bench for ram_moc_param
module tb_ram_moc_param;
    localparam logic       R = 1'b1;
    localparam logic       W = 1'b0;
    localparam logic [2:0] M_B  = 3'b000;
    localparam logic [2:0] M_BS = 3'b100;
    localparam logic [2:0] M_H  = 3'b001;
    localparam logic [2:0] M_HS = 3'b101;
    localparam logic [2:0] M_W  = 3'b010;
    localparam logic [2:0] M_D  = 3'b011;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    ram_moc_param_if ifa ();
    ram_moc_param_if ifb ();
    ram_moc_param_if ifc ();

    ram_moc_param #(.DEPTH(256), .WAIT_STATES(2), .ALIGN_CHECK(1)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
    ram_moc_param #(.DEPTH(256), .WAIT_STATES(2), .ALIGN_CHECK(0)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));
    ram_moc_param #(.DEPTH(256), .WAIT_STATES(4), .ALIGN_CHECK(1)) dut_c (.CLK(CLK), .RESET(RESET), .bus(ifc));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic drive(input int d, input logic mov, input logic rw, input logic [2:0] ms,
                         input logic [31:0] a, input logic [31:0] din);
        case (d)
            0: begin ifa.MOV = mov; ifa.RW = rw; ifa.MS = ms; ifa.Address = a; ifa.DataIn = din; end
            1: begin ifb.MOV = mov; ifb.RW = rw; ifb.MS = ms; ifb.Address = a; ifb.DataIn = din; end
            default: begin ifc.MOV = mov; ifc.RW = rw; ifc.MS = ms; ifc.Address = a; ifc.DataIn = din; end
        endcase
    endtask

    task automatic sample(input int d, output logic moc, output logic [31:0] dout,
                          output logic bt, output logic flt);
        case (d)
            0: begin moc = ifa.MOC; dout = ifa.DataOut; bt = ifa.BEAT; flt = ifa.FAULT; end
            1: begin moc = ifb.MOC; dout = ifb.DataOut; bt = ifb.BEAT; flt = ifb.FAULT; end
            default: begin moc = ifc.MOC; dout = ifc.DataOut; bt = ifc.BEAT; flt = ifc.FAULT; end
        endcase
    endtask

    // Raise MOV, hold it until MOC, drop it; lat counts edges after the capturing edge.
    task automatic op(input int d, input logic rw, input logic [2:0] ms, input logic [31:0] a,
                      input logic [31:0] din, output logic [31:0] dout, output logic flt,
                      output logic bt, output int lat);
        logic moc;
        logic [31:0] d2;
        logic b2, f2;
        moc = 1'b0; lat = 0; dout = '0; flt = 1'b0; bt = 1'b0;
        @(negedge CLK);
        drive(d, 1'b1, rw, ms, a, din);
        @(posedge CLK);
        while (!moc && lat < 40) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            sample(d, moc, dout, bt, flt);
        end
        checks++;
        if (!moc) begin
            errors++;
            $display("FAIL op_timeout dut=%0d addr=%h got moc=%b want 1", d, a, moc);
        end
        drive(d, 1'b0, rw, ms, a, din);
        @(negedge CLK);
        sample(d, moc, d2, b2, f2);
        checks++;
        if (moc !== 1'b0 || b2 !== 1'b0 || f2 !== 1'b0) begin
            errors++;
            $display("FAIL ack_exit dut=%0d got moc=%b beat=%b fault=%b want 0 0 0", d, moc, b2, f2);
        end
    endtask

    task automatic test_reset;
        logic moc, bt, flt;
        logic [31:0] dout;
        RESET = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            sample(d, moc, dout, bt, flt);
            checks++;
            if ({moc, bt, flt} !== 3'b000 || dout !== 32'd0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got moc=%b beat=%b fault=%b dout=%h want all 0", d, moc, bt, flt, dout);
            end
        end
        RESET = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] dout;
        logic flt, bt;
        int lat;
        logic [31:0] exp_b [4];
        exp_b[0] = 32'hDE; exp_b[1] = 32'hAD; exp_b[2] = 32'hBE; exp_b[3] = 32'hEF;
        op(0, W, M_W, 32'h10, 32'hDEADBEEF, dout, flt, bt, lat);
        checks++;
        if (lat != 3 || dout !== 32'd0 || flt !== 1'b0) begin
            errors++;
            $display("FAIL word_write got lat=%0d dout=%h fault=%b want 3 00000000 0", lat, dout, flt);
        end
        op(0, R, M_W, 32'h10, 32'h0, dout, flt, bt, lat);
        checks++;
        if (lat != 3 || dout !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_read got lat=%0d dout=%h want 3 deadbeef", lat, dout);
        end
        for (int i = 0; i < 4; i++) begin
            op(0, R, M_B, 32'h10 + i, 32'h0, dout, flt, bt, lat);
            checks++;
            if (dout !== exp_b[i]) begin
                errors++;
                $display("FAIL word_byte%0d got %h want %h", i, dout, exp_b[i]);
            end
        end
    endtask

    task automatic test_signed;
        logic [31:0] dout;
        logic flt, bt;
        int lat;
        logic [2:0]  ms_v [4];
        logic [31:0] exp_v [4];
        ms_v[0] = M_B;  exp_v[0] = 32'h00000080;
        ms_v[1] = M_BS; exp_v[1] = 32'hFFFFFF80;
        ms_v[2] = M_HS; exp_v[2] = 32'hFFFF8001;
        ms_v[3] = M_H;  exp_v[3] = 32'h00008001;
        op(0, W, M_H, 32'h20, 32'hAAAA8001, dout, flt, bt, lat);
        for (int i = 0; i < 4; i++) begin
            op(0, R, ms_v[i], 32'h20, 32'h0, dout, flt, bt, lat);
            checks++;
            if (dout !== exp_v[i]) begin
                errors++;
                $display("FAIL signed_load ms=%b got %h want %h", ms_v[i], dout, exp_v[i]);
            end
        end
        op(0, R, M_B, 32'h21, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h01) begin
            errors++;
            $display("FAIL half_low_byte got %h want 00000001", dout);
        end
    endtask

    task automatic test_dword;
        logic [31:0] dout;
        logic flt, bt;
        int lat;
        op(0, W, M_D, 32'h40, 32'h11223344, dout, flt, bt, lat);
        checks++;
        if (bt !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL dword_w_beat0 got beat=%b lat=%0d want 0 3", bt, lat);
        end
        op(0, W, M_B, 32'h99, 32'h55667788, dout, flt, bt, lat);
        checks++;
        if (bt !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL dword_w_beat1 got beat=%b lat=%0d want 1 3", bt, lat);
        end
        op(0, R, M_D, 32'h40, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h11223344 || bt !== 1'b0) begin
            errors++;
            $display("FAIL dword_r_beat0 got %h beat=%b want 11223344 0", dout, bt);
        end
        op(0, R, M_B, 32'h0, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h55667788 || bt !== 1'b1) begin
            errors++;
            $display("FAIL dword_r_beat1 got %h beat=%b want 55667788 1", dout, bt);
        end
        op(0, R, M_B, 32'h44, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h55) begin
            errors++;
            $display("FAIL dword_byte44 got %h want 00000055", dout);
        end
    endtask

    task automatic test_align;
        logic [31:0] dout;
        logic flt, bt;
        int lat;
        op(0, W, M_W, 32'h20, 32'h8001A5C3, dout, flt, bt, lat);
        op(0, R, M_W, 32'h20, 32'h0, dout, flt, bt, lat);
        op(0, R, M_W, 32'h22, 32'h0, dout, flt, bt, lat);
        checks++;
        if (flt !== 1'b1 || lat != 1 || dout !== 32'h8001A5C3) begin
            errors++;
            $display("FAIL align_read got fault=%b lat=%0d dout=%h want 1 1 8001a5c3", flt, lat, dout);
        end
        op(0, W, M_W, 32'h21, 32'hFFFFFFFF, dout, flt, bt, lat);
        checks++;
        if (flt !== 1'b1) begin
            errors++;
            $display("FAIL align_write_fault got %b want 1", flt);
        end
        op(0, W, M_H, 32'h23, 32'hFFFF, dout, flt, bt, lat);
        checks++;
        if (flt !== 1'b1) begin
            errors++;
            $display("FAIL align_half_fault got %b want 1", flt);
        end
        op(0, R, M_W, 32'h20, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h8001A5C3 || flt !== 1'b0) begin
            errors++;
            $display("FAIL align_mem_intact got %h fault=%b want 8001a5c3 0", dout, flt);
        end
        op(1, W, M_W, 32'h23, 32'h8001A5C3, dout, flt, bt, lat);
        op(1, R, M_W, 32'h22, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h8001A5C3 || flt !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL noalign_word got %h fault=%b lat=%0d want 8001a5c3 0 3", dout, flt, lat);
        end
        op(1, R, M_H, 32'h21, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h00008001 || flt !== 1'b0) begin
            errors++;
            $display("FAIL noalign_half got %h fault=%b want 00008001 0", dout, flt);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] dout;
        logic flt, bt;
        int lat;
        op(0, W, M_D, 32'hFC, 32'h01020304, dout, flt, bt, lat);
        op(0, W, M_D, 32'h0, 32'hCAFEF00D, dout, flt, bt, lat);
        op(0, R, M_B, 32'h00, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'hCA) begin
            errors++;
            $display("FAIL wrap_byte00 got %h want 000000ca", dout);
        end
        op(0, R, M_B, 32'hFF, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h04) begin
            errors++;
            $display("FAIL wrap_byteff got %h want 00000004", dout);
        end
        op(0, R, M_W, 32'h100, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_addr_hi got %h want cafef00d", dout);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] dout;
        logic flt, bt, moc, seen;
        int lat;
        op(2, W, M_W, 32'h30, 32'h12345678, dout, flt, bt, lat);
        op(2, R, M_W, 32'h30, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h12345678 || lat != 5) begin
            errors++;
            $display("FAIL ws4_read got %h lat=%0d want 12345678 5", dout, lat);
        end
        seen = 1'b0;
        @(negedge CLK);
        drive(2, 1'b1, W, M_W, 32'h30, 32'hAABBCCDD);
        @(posedge CLK);
        @(negedge CLK);
        sample(2, moc, dout, bt, flt);
        seen = seen | moc;
        @(posedge CLK);
        @(negedge CLK);
        sample(2, moc, dout, bt, flt);
        seen = seen | moc;
        RESET = 1'b1;
        drive(2, 1'b0, W, M_W, 32'h30, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        sample(2, moc, dout, bt, flt);
        checks++;
        if ({moc, bt, flt} !== 3'b000 || dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort_outputs got moc=%b beat=%b fault=%b dout=%h want all 0", moc, bt, flt, dout);
        end
        RESET = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            sample(2, moc, dout, bt, flt);
            seen = seen | moc;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_moc got %b want 0", seen);
        end
        op(2, R, M_W, 32'h30, 32'h0, dout, flt, bt, lat);
        checks++;
        if (dout !== 32'h12345678) begin
            errors++;
            $display("FAIL reset_abort_mem got %h want 12345678", dout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word();
        test_signed();
        test_dword();
        test_align();
        test_wrap();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
